// File: rtl/aes256_pkg.sv
// Shared AES-256 datapath types and constants.
package aes256_pkg;

    typedef logic [127:0] aes_block_t;
    typedef logic [7:0]   aes_byte_t;

    localparam int AES_BLOCK_BYTES = 16;

    // Byte-position counter inside one block.
    localparam int BCNT_W = $clog2(AES_BLOCK_BYTES);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(AES_BLOCK_BYTES - 1);

endpackage

// File: rtl/aes256_block_fifo.sv
// First-word-fall-through FIFO of 128-bit blocks.
// Storage is a plain array; the head is a register loaded from the array
// (or bypassed from the write port) so the next entry appears with no bubble.
module aes256_block_fifo
    import aes256_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     push,
    input  logic [127:0]             push_data,
    input  logic                     pop,
    output logic [127:0]             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     space
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    aes_block_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [PTR_W:0]   count_reg;
    logic [PTR_W:0]   count_after_pop;
    logic [PTR_W:0]   count_next;
    aes_block_t       head_reg;
    aes_block_t       head_next;
    logic             space_reg;
    logic             do_pop;
    logic             do_push;

    // Handshake qualification, next occupancy and next head selection.
    always_comb begin
        do_pop          = pop && (count_reg != '0);
        // A full FIFO still accepts a push when the head leaves the same cycle.
        do_push         = push && ((count_reg != DEPTH_C) || do_pop);
        count_after_pop = count_reg - (PTR_W + 1)'(do_pop);
        count_next      = count_after_pop + (PTR_W + 1)'(do_push);
        rd_ptr_next     = rd_ptr_reg + PTR_W'(do_pop);
        head_next       = head_reg;
        if (do_push && (count_after_pop == '0)) begin
            // Nothing left behind the head: the incoming block becomes the head.
            head_next = push_data;
        end else if (count_after_pop != '0) begin
            head_next = mem[rd_ptr_next];
        end
    end

    // Block storage; intentionally not reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers, occupancy, registered head and registered space flag.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
            space_reg  <= 1'b1;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(do_push);
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            head_reg   <= head_next;
            space_reg  <= (count_next < DEPTH_C);
        end
    end

    assign head  = head_reg;
    assign full  = (count_reg == DEPTH_C);
    assign empty = (count_reg == '0);
    assign count = count_reg;
    assign space = space_reg;

endmodule

// File: rtl/aes256_ct_collector.sv
// Reassembles byte-serial ciphertext (MSB first) into 128-bit blocks and
// buffers them in a FWFT FIFO behind a valid/ready port.
module aes256_ct_collector
    import aes256_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             pi_rst,
    input  logic             pi_byte_valid,
    input  logic [7:0]       pi_byte,
    input  logic             pi_abort,
    input  logic             pi_clear_ovf,
    output logic             po_space,
    output logic             po_ct_valid,
    output logic [127:0]     po_ct,
    input  logic             pi_ct_ready,
    output logic             po_partial,
    output logic             po_overflow,
    output logic [CNT_W-1:0] po_block_count
);

    logic [BCNT_W-1:0]    bcnt_reg;
    logic [119:0]         sreg_reg;
    logic                 ovf_reg;
    logic [CNT_W-1:0]     blk_cnt_reg;

    logic                 accept;
    logic                 complete;
    logic                 pop_fire;
    logic                 drop;
    aes_block_t           new_block;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;

    // Byte acceptance, block completion and drop detection.
    always_comb begin
        // Abort beats a simultaneous byte: that byte is discarded.
        accept    = pi_byte_valid && !pi_abort;
        complete  = accept && (bcnt_reg == BCNT_LAST);
        new_block = {sreg_reg, pi_byte};
        pop_fire  = pi_ct_ready && (fifo_count != '0);
        drop      = complete && fifo_full && !pop_fire;
    end

    aes256_block_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .srst      (pi_rst),
        .push      (complete),
        .push_data (new_block),
        .pop       (pi_ct_ready),
        .head      (po_ct),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .space     (po_space)
    );

    // Byte counter and shift register; the counter wraps to 0 after byte 15.
    always_ff @(posedge clk) begin
        if (pi_rst) begin
            bcnt_reg <= '0;
        end else if (pi_abort) begin
            bcnt_reg <= '0;
        end else if (pi_byte_valid) begin
            bcnt_reg <= bcnt_reg + BCNT_W'(1);
            sreg_reg <= {sreg_reg[111:0], pi_byte};
        end
    end

    // Sticky overflow (set wins over clear) and pushed-block counter.
    always_ff @(posedge clk) begin
        if (pi_rst) begin
            ovf_reg     <= 1'b0;
            blk_cnt_reg <= '0;
        end else begin
            if (drop) begin
                ovf_reg <= 1'b1;
            end else if (pi_clear_ovf) begin
                ovf_reg <= 1'b0;
            end
            if (complete && !drop) begin
                blk_cnt_reg <= blk_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign po_ct_valid    = !fifo_empty;
    assign po_partial     = (bcnt_reg != '0);
    assign po_overflow    = ovf_reg;
    assign po_block_count = blk_cnt_reg;

endmodule
